// File: rtl/video_raster_gen.sv
// video_raster_gen: parametrised raster timing generator (beam counters, blank/sync,
// fetch window, line/frame interrupts, flash, CPU slot). Optional light pen: VRG_LPEN_EN.
module video_raster_gen #(
  parameter int unsigned H_TOTAL       = 384,
  parameter int unsigned V_TOTAL       = 312,
  parameter int unsigned H_BLANK_START = 28,
  parameter int unsigned H_BLANK_END   = 108,
  parameter int unsigned H_SYNC_START  = 44,
  parameter int unsigned H_SYNC_END    = 76,
  parameter int unsigned V_BLANK_START = 236,
  parameter int unsigned V_BLANK_END   = 260,
  parameter int unsigned V_SYNC_START  = 240,
  parameter int unsigned V_SYNC_END    = 244,
  parameter int unsigned H_ACT_START   = 128,
  parameter int unsigned V_ACT_LINES   = 192,
  parameter int unsigned NUM_LINE_INT  = 2,
  parameter int unsigned CPU_SLOT      = 5,
  parameter int unsigned FLASH_BITS    = 5
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic                          ce_pix_p,
  input  logic                          ce_pix_n,
  input  logic                          cfg_we,
  input  logic [2:0]                    cfg_idx,
  input  logic [8:0]                    cfg_line,
`ifdef VRG_LPEN_EN
  input  logic                          lpen_strobe,
  output logic [7:0]                    lpen_h,
  output logic [8:0]                    lpen_v,
  output logic                          lpen_valid,
`endif
  output logic [$clog2(H_TOTAL)-1:0]    hc,
  output logic [$clog2(V_TOTAL)-1:0]    vc,
  output logic                          hblank,
  output logic                          vblank,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          fetch_strobe,
  output logic                          active,
  output logic [NUM_LINE_INT-1:0]       int_line,
  output logic                          int_frame,
  output logic                          flash,
  output logic                          io_contention
);

  localparam int unsigned HW = $clog2(H_TOTAL);
  localparam int unsigned VW = $clog2(V_TOTAL);

  logic [FLASH_BITS-1:0]   flash_cnt;
  logic [8:0]              line_reg [NUM_LINE_INT];
  logic [31:0]             hpos;
  logic [31:0]             vpos;
  logic                    h_last;
  logic                    v_last;
  logic                    in_hfront;
  logic                    in_window;
  logic [NUM_LINE_INT-1:0] line_hit;

  assign hpos      = 32'(hc);
  assign vpos      = 32'(vc);
  assign h_last    = (hpos == H_TOTAL - 1);
  assign v_last    = (vpos == V_TOTAL - 1);
  assign in_hfront = (hpos < H_ACT_START);
  assign in_window = (hpos >= H_ACT_START) && (vpos < V_ACT_LINES);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hc        <= '0;
      vc        <= '0;
      flash_cnt <= '0;
    end else if (ce_pix_p) begin
      if (h_last) begin
        hc <= '0;
        if (v_last) begin
          vc        <= '0;
          flash_cnt <= flash_cnt + FLASH_BITS'(1);
        end else begin
          vc <= vc + VW'(1);
        end
      end else begin
        hc <= hc + HW'(1);
      end
    end
  end

  // Out-of-range channel indices match no loop iteration and are dropped.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LINE_INT; i++) line_reg[i] <= '1;
    end else if (cfg_we) begin
      for (int unsigned i = 0; i < NUM_LINE_INT; i++)
        if (32'(cfg_idx) == i) line_reg[i] <= cfg_line;
    end
  end

  always_comb begin
    line_hit = '0;
    for (int unsigned i = 0; i < NUM_LINE_INT; i++)
      line_hit[i] = (32'(line_reg[i]) < V_ACT_LINES) && (32'(line_reg[i]) == vpos) && in_hfront;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hblank       <= 1'b0;
      vblank       <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      fetch_strobe <= 1'b0;
      active       <= 1'b0;
      int_line     <= '0;
      int_frame    <= 1'b0;
    end else if (ce_pix_n) begin
      if (hpos == H_BLANK_START)    hblank <= 1'b1;
      else if (hpos == H_BLANK_END) hblank <= 1'b0;
      if (hpos == H_SYNC_START)     hsync  <= 1'b1;
      else if (hpos == H_SYNC_END)  hsync  <= 1'b0;
      if (vpos == V_BLANK_START && hpos == H_BLANK_START)  vblank <= 1'b1;
      else if (vpos == V_BLANK_END && hpos == H_BLANK_END) vblank <= 1'b0;
      vsync        <= (vpos >= V_SYNC_START) && (vpos < V_SYNC_END);
      fetch_strobe <= in_window && (hc[2:0] == 3'b000);
      active       <= in_window;
      int_line     <= line_hit;
      int_frame    <= (vpos == V_SYNC_END) && in_hfront;
    end
  end

  assign flash         = flash_cnt[FLASH_BITS-1];
  assign io_contention = (hc[2:0] != 3'(CPU_SLOT));

`ifdef VRG_LPEN_EN
  logic lpen_d;
  logic frame_wrap;

  assign frame_wrap = ce_pix_p && h_last && v_last;

  // One capture per frame; the wrap clear takes priority over a same-cycle strobe.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lpen_d     <= 1'b0;
      lpen_h     <= '0;
      lpen_v     <= '0;
      lpen_valid <= 1'b0;
    end else begin
      lpen_d <= lpen_strobe;
      if (frame_wrap) begin
        lpen_valid <= 1'b0;
      end else if (lpen_strobe && !lpen_d && active && !lpen_valid) begin
        lpen_h     <= 8'(hc) & 8'hF8;
        lpen_v     <= 9'(vc);
        lpen_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
